// File: rtl/crono_pkg.sv
// crono_pkg: shared FSM states, BCD limits and register-select codes for the countdown timer
package crono_pkg;
  typedef enum logic [1:0] {IDLE, RUN, DONE} crono_state_t;
  localparam logic [7:0] BCD_MAX_MS = 8'h59;
  localparam logic [7:0] BCD_MAX_H = 8'h23;
  localparam logic [3:0] SEL_SEGCR_DEF = 4'd6;
  localparam logic [3:0] SEL_MINCR_DEF = 4'd7;
  localparam logic [3:0] SEL_HORACR_DEF = 4'd8;
  function automatic logic [7:0] bcd_clamp(input logic [7:0] v, input logic [7:0] max_v);
    return (v[3:0] > 4'd9 || v > max_v) ? max_v : v;
  endfunction
endpackage

// File: rtl/bcd_dec_2d.sv
// bcd_dec_2d: two-digit BCD decrement with wrap to MAX_BCD and borrow out
module bcd_dec_2d
  import crono_pkg::*;
#(
  parameter logic [7:0] MAX_BCD = BCD_MAX_MS
)(
  input  logic [7:0] i_in,
  input  logic       i_borrow_in,
  output logic [7:0] o_out,
  output logic       o_borrow_out
);
  always_comb begin
    o_borrow_out = i_borrow_in && i_in == 8'h00;
    o_out = !i_borrow_in ? i_in :
            o_borrow_out ? MAX_BCD :
            i_in[3:0] == 4'h0 ? {i_in[7:4] - 4'd1, 4'h9} :
            {i_in[7:4], i_in[3:0] - 4'd1};
  end
endmodule

// File: rtl/crono_countdown_bcd.sv
// crono_countdown_bcd: BCD hh:mm:ss countdown timer with preset load, pause and timed ring
module crono_countdown_bcd
  import crono_pkg::*;
#(
  parameter logic [3:0] SEL_SEGCR  = SEL_SEGCR_DEF,
  parameter logic [3:0] SEL_MINCR  = SEL_MINCR_DEF,
  parameter logic [3:0] SEL_HORACR = SEL_HORACR_DEF,
  parameter int         RING_SECS  = 10
)(
  input  logic        reloj,
  input  logic        resetM,
  input  logic        READ,
  input  logic [3:0]  Selec_Demux_DDw,
  input  logic [7:0]  IN_segcr,
  input  logic [7:0]  IN_mincr,
  input  logic [7:0]  IN_horacr,
  input  logic        act_crono,
  input  logic        tick_1hz,
  input  logic        stop_ring,
  output logic [23:0] alarma,
  output logic        crono_fin,
  output logic        ring
);
  localparam int CW = $clog2(RING_SECS + 1);
  crono_state_t  r_state;
  logic [23:0]   r_alarma;
  logic          r_ring;
  logic [CW-1:0] r_ring_cnt;
  logic          w_ld_s, w_ld_m, w_ld_h, w_load;
  logic [23:0]   w_loaded, w_dec;
  logic          w_b_ss, w_b_mm, w_b_hh;
  logic [CW-1:0] w_cnt_nxt;
  assign w_ld_s = READ && Selec_Demux_DDw == SEL_SEGCR;
  assign w_ld_m = READ && Selec_Demux_DDw == SEL_MINCR;
  assign w_ld_h = READ && Selec_Demux_DDw == SEL_HORACR;
  assign w_load = w_ld_s || w_ld_m || w_ld_h;
  assign w_loaded = {w_ld_h ? bcd_clamp(IN_horacr, BCD_MAX_H) : r_alarma[23:16],
                     w_ld_m ? bcd_clamp(IN_mincr, BCD_MAX_MS) : r_alarma[15:8],
                     w_ld_s ? bcd_clamp(IN_segcr, BCD_MAX_MS) : r_alarma[7:0]};
  assign w_cnt_nxt = r_ring_cnt + 1'b1;
  bcd_dec_2d #(.MAX_BCD(BCD_MAX_MS)) u_ss (
    .i_in(r_alarma[7:0]), .i_borrow_in(tick_1hz), .o_out(w_dec[7:0]), .o_borrow_out(w_b_ss));
  bcd_dec_2d #(.MAX_BCD(BCD_MAX_MS)) u_mm (
    .i_in(r_alarma[15:8]), .i_borrow_in(w_b_ss), .o_out(w_dec[15:8]), .o_borrow_out(w_b_mm));
  bcd_dec_2d #(.MAX_BCD(BCD_MAX_H)) u_hh (
    .i_in(r_alarma[23:16]), .i_borrow_in(w_b_mm), .o_out(w_dec[23:16]), .o_borrow_out(w_b_hh));
  // a borrow out of the hours digit would mean 00:00:00 wrapping to 23:59:59, so it blocks the update
  always_ff @(posedge reloj) begin
    if (resetM) begin
      r_state    <= IDLE;
      r_alarma   <= '0;
      r_ring     <= 1'b0;
      r_ring_cnt <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_load) r_alarma <= w_loaded;
          else if (act_crono) begin
            r_state    <= (r_alarma == '0) ? DONE : RUN;
            r_ring     <= r_alarma == '0;
            r_ring_cnt <= '0;
          end
        end
        RUN: begin
          if (tick_1hz && !w_b_hh) r_alarma <= w_dec;
          if (tick_1hz && !w_b_hh && w_dec == '0) begin
            r_state    <= DONE;
            r_ring     <= 1'b1;
            r_ring_cnt <= '0;
          end else if (!act_crono) r_state <= IDLE;
        end
        DONE: begin
          if (w_load || !act_crono) begin
            r_state <= IDLE;
            r_ring  <= 1'b0;
            if (w_load) r_alarma <= w_loaded;
          end else if (stop_ring) r_ring <= 1'b0;
          else if (tick_1hz && r_ring) begin
            r_ring_cnt <= w_cnt_nxt;
            if (w_cnt_nxt == CW'(RING_SECS)) r_ring <= 1'b0;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end
  assign alarma    = r_alarma;
  assign crono_fin = r_state == DONE;
  assign ring      = r_ring;
endmodule

// File: tb/tb_crono_countdown_bcd.sv
// tb_crono_countdown_bcd: directed vector table plus random run against a seconds-based model
module tb_crono_countdown_bcd;
  localparam int RS = 3;
  logic        reloj = 1'b0;
  logic        resetM, READ, act_crono, tick_1hz, stop_ring;
  logic [3:0]  Selec_Demux_DDw;
  logic [7:0]  IN_segcr, IN_mincr, IN_horacr;
  logic [23:0] alarma;
  logic        crono_fin, ring;
  int n_chk = 0;
  int n_fail = 0;

  crono_countdown_bcd #(.RING_SECS(RS)) dut (
    .reloj(reloj), .resetM(resetM), .READ(READ), .Selec_Demux_DDw(Selec_Demux_DDw),
    .IN_segcr(IN_segcr), .IN_mincr(IN_mincr), .IN_horacr(IN_horacr),
    .act_crono(act_crono), .tick_1hz(tick_1hz), .stop_ring(stop_ring),
    .alarma(alarma), .crono_fin(crono_fin), .ring(ring));

  always #5 reloj = ~reloj;

  typedef struct {
    logic rst, rd;
    logic [3:0] sel;
    logic [7:0] d;
    logic act, tk, stp;
    logic [23:0] e_al;
    logic e_fin, e_rng;
  } vec_t;
  vec_t tbl[$];

  function automatic void v(int rst, int rd, int sel, int d, int act, int tk, int stp,
                            int e_al, int e_fin, int e_rng);
    tbl.push_back('{rst != 0, rd != 0, 4'(sel), 8'(d), act != 0, tk != 0, stp != 0,
                    24'(e_al), e_fin != 0, e_rng != 0});
  endfunction

  // Model keeps the remaining time as a plain count of seconds
  int   m_secs = 0, m_st = 0, m_cnt = 0;
  logic m_ring = 1'b0;

  function automatic logic [7:0] to_b(int n);
    return 8'((n / 10) * 16 + n % 10);
  endfunction

  function automatic logic [23:0] m_bcd();
    return {to_b(m_secs / 3600), to_b(m_secs / 60 % 60), to_b(m_secs % 60)};
  endfunction

  function automatic int clampv(logic [7:0] b, int mx);
    int hi = int'(b[7:4]);
    int lo = int'(b[3:0]);
    return (lo > 9 || hi * 10 + lo > mx) ? mx : hi * 10 + lo;
  endfunction

  function automatic void model_step();
    int h = m_secs / 3600;
    int m = m_secs / 60 % 60;
    int s = m_secs % 60;
    logic ld = READ && (Selec_Demux_DDw == 4'd6 || Selec_Demux_DDw == 4'd7 || Selec_Demux_DDw == 4'd8);
    if (READ && Selec_Demux_DDw == 4'd6) s = clampv(IN_segcr, 59);
    if (READ && Selec_Demux_DDw == 4'd7) m = clampv(IN_mincr, 59);
    if (READ && Selec_Demux_DDw == 4'd8) h = clampv(IN_horacr, 23);
    if (resetM) begin
      m_secs = 0; m_st = 0; m_ring = 1'b0; m_cnt = 0;
    end else if (m_st == 0) begin
      if (ld) m_secs = h * 3600 + m * 60 + s;
      else if (act_crono) begin
        m_st = (m_secs == 0) ? 2 : 1;
        m_ring = m_secs == 0;
        m_cnt = 0;
      end
    end else if (m_st == 1) begin
      if (tick_1hz) m_secs--;
      if (tick_1hz && m_secs == 0) begin
        m_st = 2; m_ring = 1'b1; m_cnt = 0;
      end else if (!act_crono) m_st = 0;
    end else begin
      if (ld || !act_crono) begin
        if (ld) m_secs = h * 3600 + m * 60 + s;
        m_st = 0; m_ring = 1'b0;
      end else if (stop_ring) m_ring = 1'b0;
      else if (tick_1hz) begin
        m_cnt++;
        if (m_cnt >= RS) m_ring = 1'b0;
      end
    end
  endfunction

  function automatic void chk(string nm, logic [23:0] got, logic [23:0] want);
    n_chk++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s got=%h want=%h", nm, got, want);
    end
  endfunction

  task automatic cyc();
    model_step();
    @(posedge reloj);
    #1;
  endtask

  initial begin
    {resetM, READ, act_crono, tick_1hz, stop_ring} = '0;
    Selec_Demux_DDw = '0;
    {IN_segcr, IN_mincr, IN_horacr} = '0;
    // reset mid-RUN, then IDLE with zero -> DONE, load in DONE
    v(1,0,0,0,0,0,0,'h000000,0,0);
    v(0,1,6,'h05,0,0,0,'h000005,0,0);
    v(0,0,0,0,1,0,0,'h000005,0,0);
    v(0,0,0,0,1,1,0,'h000004,0,0);
    v(1,0,0,0,1,1,0,'h000000,0,0);
    v(0,0,0,0,0,0,0,'h000000,0,0);
    v(0,0,0,0,1,0,0,'h000000,1,1);
    v(0,1,6,'h30,1,0,0,'h000030,0,0);
    v(0,1,5,'h11,0,0,0,'h000030,0,0);
    v(0,1,8,'h1F,0,0,0,'h230030,0,0);
    // borrow across minutes and hours
    v(1,0,0,0,0,0,0,'h000000,0,0);
    v(0,1,8,'h01,0,0,0,'h010000,0,0);
    v(0,0,0,0,1,0,0,'h010000,0,0);
    v(0,0,0,0,1,1,0,'h005959,0,0);
    v(0,0,0,0,0,0,0,'h005959,0,0);
    // clamping and load ignored in RUN
    v(1,0,0,0,0,0,0,'h000000,0,0);
    v(0,1,6,'h75,0,0,0,'h000059,0,0);
    v(0,1,8,'h3A,0,0,0,'h230059,0,0);
    v(0,0,0,0,1,0,0,'h230059,0,0);
    v(0,1,7,'h12,1,0,0,'h230059,0,0);
    v(0,0,0,0,1,1,0,'h230058,0,0);
    v(0,0,0,0,0,0,0,'h230058,0,0);
    v(0,1,7,'h1A,0,0,0,'h235958,0,0);
    // reach zero, ring for RS ticks
    v(1,0,0,0,0,0,0,'h000000,0,0);
    v(0,1,6,'h02,0,0,0,'h000002,0,0);
    v(0,0,0,0,1,0,0,'h000002,0,0);
    v(0,0,0,0,1,1,0,'h000001,0,0);
    v(0,0,0,0,1,1,0,'h000000,1,1);
    v(0,0,0,0,1,1,0,'h000000,1,1);
    v(0,0,0,0,1,0,0,'h000000,1,1);
    v(0,0,0,0,1,1,0,'h000000,1,1);
    v(0,0,0,0,1,1,0,'h000000,1,0);
    v(0,0,0,0,1,1,0,'h000000,1,0);
    v(0,0,0,0,0,0,0,'h000000,0,0);
    // same run silenced by stop_ring
    v(0,1,6,'h02,0,0,0,'h000002,0,0);
    v(0,0,0,0,1,0,0,'h000002,0,0);
    v(0,0,0,0,1,1,0,'h000001,0,0);
    v(0,0,0,0,1,1,0,'h000000,1,1);
    v(0,0,0,0,1,1,0,'h000000,1,1);
    v(0,0,0,0,1,0,1,'h000000,1,0);
    v(0,0,0,0,0,0,0,'h000000,0,0);
    // pause on the same edge as a tick
    v(1,0,0,0,0,0,0,'h000000,0,0);
    v(0,1,7,'h01,0,0,0,'h000100,0,0);
    v(0,0,0,0,1,0,0,'h000100,0,0);
    v(0,0,0,0,0,1,0,'h000059,0,0);
    v(0,0,0,0,0,1,0,'h000059,0,0);
    v(0,0,0,0,0,1,0,'h000059,0,0);
    v(0,0,0,0,1,0,0,'h000059,0,0);
    v(0,0,0,0,1,1,0,'h000058,0,0);
    v(0,0,0,0,0,0,0,'h000058,0,0);
    foreach (tbl[i]) begin
      resetM = tbl[i].rst;
      READ = tbl[i].rd;
      Selec_Demux_DDw = tbl[i].sel;
      {IN_segcr, IN_mincr, IN_horacr} = {3{tbl[i].d}};
      act_crono = tbl[i].act;
      tick_1hz = tbl[i].tk;
      stop_ring = tbl[i].stp;
      cyc();
      chk($sformatf("vec%0d alarma", i), alarma, tbl[i].e_al);
      chk($sformatf("vec%0d crono_fin", i), 24'(crono_fin), 24'(tbl[i].e_fin));
      chk($sformatf("vec%0d ring", i), 24'(ring), 24'(tbl[i].e_rng));
    end
    for (int c = 0; c < 4000; c++) begin
      resetM = $urandom_range(0, 299) == 0;
      READ = $urandom_range(0, 5) == 0;
      Selec_Demux_DDw = 4'($urandom_range(5, 9));
      IN_segcr = ($urandom_range(0, 3) == 0) ? 8'($urandom) : to_b(int'($urandom_range(0, 5)));
      IN_mincr = ($urandom_range(0, 3) == 0) ? 8'($urandom) : to_b(int'($urandom_range(0, 2)));
      IN_horacr = ($urandom_range(0, 7) == 0) ? 8'($urandom) : to_b(int'($urandom_range(0, 1)));
      if ($urandom_range(0, 19) == 0) act_crono = ~act_crono;
      tick_1hz = $urandom_range(0, 2) == 0;
      stop_ring = $urandom_range(0, 14) == 0;
      cyc();
      chk($sformatf("rnd%0d alarma", c), alarma, m_bcd());
      chk($sformatf("rnd%0d crono_fin", c), 24'(crono_fin), 24'(m_st == 2));
      chk($sformatf("rnd%0d ring", c), 24'(ring), 24'(m_ring));
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
